// File: rtl/shift_reg_univ_en.sv
// Universal shift register with clock enable.
// Modes: hold, shift right/left, rotate right/left, parallel load, clear, invert.
// A shift counter pulses word_done_out for one enabled cycle after every
// WIDTH counted shifts, so the block can act as a serializer or deserializer.
module shift_reg_univ_en #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_ah_in,
    input  logic             en_in,
    input  logic [2:0]       mode_in,
    input  logic [WIDTH-1:0] d_in,
    input  logic             ser_msb_in,
    input  logic             ser_lsb_in,
    output logic [WIDTH-1:0] q_out,
    output logic             ser_msb_out,
    output logic             ser_lsb_out,
    output logic             word_done_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHR   = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_ROTR  = 3'b011,
        MODE_ROTL  = 3'b100,
        MODE_LOAD  = 3'b101,
        MODE_CLEAR = 3'b110,
        MODE_INV   = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             counted;

    // Next-state: data path by mode, then shift counting and word-done pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = done_q;   // disabled edges hold a pending pulse
        counted = 1'b0;

        if (en_in) begin
            done_d = 1'b0;
            unique case (mode_e'(mode_in))
                MODE_HOLD:  q_d = q_q;
                MODE_SHR: begin
                    q_d     = {ser_msb_in, q_q[WIDTH-1:1]};
                    counted = 1'b1;
                end
                MODE_SHL: begin
                    q_d     = {q_q[WIDTH-2:0], ser_lsb_in};
                    counted = 1'b1;
                end
                MODE_ROTR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                MODE_ROTL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_LOAD: begin
                    q_d   = d_in;
                    cnt_d = '0;
                end
                MODE_CLEAR: begin
                    q_d   = '0;
                    cnt_d = '0;
                end
                MODE_INV:   q_d = ~q_q;
                default:    q_d = q_q;
            endcase

            // The count wraps on the WIDTH-th shift instead of ever holding WIDTH.
            if (counted) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d  = '0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset that overrides enable and mode.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops
        // sample their inputs from the same pre-edge values.
        if (reset_ah_in) begin
            q_q    <= RESET_VAL;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q_out         = q_q;
    assign ser_msb_out   = q_q[WIDTH-1];
    assign ser_lsb_out   = q_q[0];
    assign word_done_out = done_q;

endmodule

// File: tb/tb_shift_reg_univ_en.sv
// Self-checking bench for shift_reg_univ_en: directed steps from the test
// plan followed by random traffic, all compared against an arithmetic model.
module tb_shift_reg_univ_en;

    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset_ah_in = 1'b0;
    logic         en_in = 1'b0;
    logic [2:0]   mode_in = 3'b000;
    logic [W-1:0] d_in = '0;
    logic         ser_msb_in = 1'b0;
    logic         ser_lsb_in = 1'b0;
    logic [W-1:0] q_out;
    logic         ser_msb_out;
    logic         ser_lsb_out;
    logic         word_done_out;

    int checks   = 0;
    int failures = 0;

    // Reference model: the word as an integer, shifts counted within a word.
    int m_q      = 0;
    int m_shifts = 0;
    bit m_done   = 1'b0;

    shift_reg_univ_en #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk           (clk),
        .reset_ah_in   (reset_ah_in),
        .en_in         (en_in),
        .mode_in       (mode_in),
        .d_in          (d_in),
        .ser_msb_in    (ser_msb_in),
        .ser_lsb_in    (ser_lsb_in),
        .q_out         (q_out),
        .ser_msb_out   (ser_msb_out),
        .ser_lsb_out   (ser_lsb_out),
        .word_done_out (word_done_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the behavioural rules.
    task automatic model_edge(input bit rst, input bit en, input int mode,
                              input int d, input int sm, input int sl);
        int  top;
        bit  shifted;
        top     = 1 << W;
        shifted = 1'b0;
        if (rst) begin
            m_q = int'(RV); m_shifts = 0; m_done = 1'b0;
        end else if (en) begin
            m_done = 1'b0;
            case (mode)
                1: begin m_q = m_q / 2 + sm * (top / 2); shifted = 1'b1; end
                2: begin m_q = (m_q * 2) % top + sl;     shifted = 1'b1; end
                3: m_q = m_q / 2 + (m_q % 2) * (top / 2);
                4: m_q = (m_q * 2) % top + m_q / (top / 2);
                5: begin m_q = d; m_shifts = 0; end
                6: begin m_q = 0; m_shifts = 0; end
                7: m_q = (top - 1) - m_q;
                default: ;
            endcase
            if (shifted) begin
                m_shifts++;
                if (m_shifts == W) begin
                    m_shifts = 0;
                    m_done   = 1'b1;
                end
            end
        end
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later, compare.
    task automatic step(input string tag, input bit rst, input bit en, input int mode,
                        input int d, input int sm, input int sl);
        reset_ah_in = rst;
        en_in       = en;
        mode_in     = 3'(mode);
        d_in        = W'(d);
        ser_msb_in  = sm[0];
        ser_lsb_in  = sl[0];
        @(posedge clk);
        #1;
        model_edge(rst, en, mode, d, sm, sl);
        check({tag, ":q"},    32'(q_out),         32'(m_q));
        check({tag, ":done"}, 32'(word_done_out), 32'(m_done));
        check({tag, ":msb"},  32'(ser_msb_out),   32'((m_q >> (W - 1)) & 1));
        check({tag, ":lsb"},  32'(ser_lsb_out),   32'(m_q & 1));
    endtask

    int          bits_a [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    int          lsb_seq[8] = '{0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        // Reset with enable high and a load pending.
        step("rst_en1_a", 1, 1, 5, 8'hFF, 0, 0);
        step("rst_en1_b", 1, 1, 5, 8'hFF, 0, 0);
        check("rst_en1_q", 32'(q_out), 32'h A5);
        check("rst_en1_done", 32'(word_done_out), 0);
        step("load_ff", 0, 1, 5, 8'hFF, 0, 0);
        step("rst_en0_a", 1, 0, 5, 8'hFF, 0, 0);
        step("rst_en0_b", 1, 0, 5, 8'hFF, 0, 0);
        check("rst_en0_q", 32'(q_out), 32'h A5);

        // Parallel load and rotate.
        step("load_81", 0, 1, 5, 8'h81, 0, 0);
        step("rotl1", 0, 1, 4, 0, 0, 0);
        check("rotl1_const", 32'(q_out), 32'h03);
        step("rotl2", 0, 1, 4, 0, 0, 0);
        check("rotl2_const", 32'(q_out), 32'h06);
        step("rotl3", 0, 1, 4, 0, 0, 0);
        check("rotl3_const", 32'(q_out), 32'h0C);
        step("rotr1", 0, 1, 3, 0, 0, 0);
        check("rotr1_const", 32'(q_out), 32'h06);

        // Deserialize, then a back-to-back second word.
        step("clr_a", 0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 8; i++) step("deser_a", 0, 1, 2, 0, 0, bits_a[i]);
        check("deser_q", 32'(q_out), 32'hB2);
        check("deser_pulse", 32'(word_done_out), 1);
        for (int i = 0; i < 8; i++) begin
            step("deser_b", 0, 1, 2, 0, 0, i % 2);
            if (i < 7) check("deser_b_nopulse", 32'(word_done_out), 0);
        end
        check("deser_b_pulse", 32'(word_done_out), 1);

        // Enable gating mid-word, then a pulse stretched by a disabled cycle.
        step("clr_g", 0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("gate_pre", 0, 1, 2, 0, 0, bits_a[i]);
        for (int i = 0; i < 3; i++) step("gate_off", 0, 0, 2, 0, 0, 1);
        check("gate_frozen", 32'(q_out), 32'h0B);
        for (int i = 4; i < 8; i++) step("gate_post", 0, 1, 2, 0, 0, bits_a[i]);
        check("gate_q", 32'(q_out), 32'hB2);
        check("gate_pulse", 32'(word_done_out), 1);
        step("stretch_off", 0, 0, 2, 0, 0, 0);
        check("stretch_held", 32'(word_done_out), 1);
        step("stretch_on", 0, 1, 0, 0, 0, 0);
        check("stretch_end", 32'(word_done_out), 0);

        // Mid-word interrupt by a load.
        step("clr_m", 0, 1, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) step("mid_shr", 0, 1, 1, 0, 1, 0);
        step("mid_load", 0, 1, 5, 8'h3C, 0, 0);
        check("mid_load_nopulse", 32'(word_done_out), 0);
        for (int i = 0; i < 8; i++) begin
            check("mid_lsb_seq", 32'(ser_lsb_out), 32'(lsb_seq[i]));
            step("mid_post", 0, 1, 1, 0, 0, 0);
        end
        check("mid_q", 32'(q_out), 32'h00);
        check("mid_pulse", 32'(word_done_out), 1);

        // Invert, clear, reset on the would-be final shift.
        step("load_5a", 0, 1, 5, 8'h5A, 0, 0);
        step("inv", 0, 1, 7, 0, 0, 0);
        check("inv_const", 32'(q_out), 32'hA5);
        step("clr_i", 0, 1, 6, 0, 0, 0);
        check("clr_const", 32'(q_out), 32'h00);
        for (int i = 0; i < 7; i++) step("pre_rst", 0, 1, 2, 0, 0, 1);
        step("rst_on_8th", 1, 1, 2, 0, 0, 1);
        check("rst8_q", 32'(q_out), 32'hA5);
        check("rst8_nopulse", 32'(word_done_out), 0);

        // Random traffic, biased toward counted shifts so pulses occur often.
        for (int i = 0; i < 400; i++) begin
            int m;
            m = int'($urandom_range(0, 11));
            if (m > 7) m = (m % 2) + 1;
            step("rand", ($urandom_range(0, 40) == 0), ($urandom_range(0, 3) != 0), m,
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_reg_univ_en.md
# shift_reg_univ_en

Parametrised universal shift register with clock enable, the successor to the team's single-bit load-enabled D flip-flop. It holds a WIDTH-bit word and supports several modes: hold, shift, rotate, parallel load, clear and invert. A shift counter raises a one-cycle word-complete pulse after WIDTH serial shifts. It sits between serial links and parallel datapaths as both a serializer and a deserializer.

## Interface
- WIDTH, 8, register width in bits; legal range 2..32.
- RESET_VAL, 0, value loaded into q_out on reset (WIDTH bits).

- clk  input  1  rising-edge clock; the only clock.
- reset_ah_in  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
- en_in  input  1  clock enable; when low, all state holds.
- mode_in  input  3  operation select (see Operation).
- d_in  input  WIDTH  parallel load data.
- ser_msb_in  input  1  serial bit entering at the MSB on a shift right.
- ser_lsb_in  input  1  serial bit entering at the LSB on a shift left.
- q_out  output  WIDTH  register contents.
- ser_msb_out  output  1  equals q_out[WIDTH-1]; combinational from the register.
- ser_lsb_out  output  1  equals q_out[0]; combinational from the register.
- word_done_out  output  1  registered one-cycle pulse after the WIDTH-th shift.

## Operation
- Priority at each rising clk edge: reset_ah_in > en_in low > mode_in.
- Reset (reset_ah_in=1):
  - q_out <= RESET_VAL.
  - Internal shift count <= 0.
  - word_done_out <= 0.
  - Reset applies regardless of en_in and mode_in.
- en_in=0: q_out, the count and word_done_out all hold their previous values.
  - Because word_done_out holds, a pending pulse stretches until the next enabled edge.
- mode_in, applied when en_in=1:
  - 000 hold: q unchanged; count unchanged.
  - 001 shift right: q <= {ser_msb_in, q[WIDTH-1:1]}; counts a shift.
  - 010 shift left: q <= {q[WIDTH-2:0], ser_lsb_in}; counts a shift.
  - 011 rotate right: q <= {q[0], q[WIDTH-1:1]}; count unchanged.
  - 100 rotate left: q <= {q[WIDTH-2:0], q[WIDTH-1]}; count unchanged.
  - 101 parallel load: q <= d_in; count <= 0.
  - 110 clear: q <= 0; count <= 0.
  - 111 invert: q <= ~q; count unchanged.
- Shift counter:
  - Width is clog2(WIDTH+1) bits.
  - Increments on each counted shift.
  - When a counted shift makes it reach WIDTH, it wraps to 0 on that same edge and word_done_out <= 1.
  - It never holds the value WIDTH.
- word_done_out:
  - On every enabled edge without a wrap, word_done_out <= 0.
  - A pulse therefore lasts exactly one enabled cycle.
  - Back-to-back words (continuous shifting) give a pulse every WIDTH enabled cycles with no gap cycles.
- Mixed shift directions: left and right shifts both count toward the same total.
- Load or clear mid-word: discards the partial count; no pulse is generated.

## Timing
- All state updates on the rising edge of clk; there are no asynchronous paths.
- Latency from mode_in/d_in/serial inputs to q_out: 1 cycle.
- ser_msb_out and ser_lsb_out change in the same cycle as q_out.
- word_done_out rises in the cycle after the edge that performs the WIDTH-th shift, coincident with the fully assembled q_out.
- Reset mid-word: the next cycle shows q_out=RESET_VAL, count 0 and word_done_out=0, even if that edge would have been the WIDTH-th shift.
- Reset while en_in=0 still takes effect.
- Inputs must meet setup/hold to clk; no internal synchronisers.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5.
  - Drive reset_ah_in=1 for 2 edges with en_in=1, mode_in=101, d_in=8'hFF.
  - Required: q_out=8'hA5 and word_done_out=0. Repeat with en_in=0 and get the same result.
- Parallel load and rotate:
  - Load 8'h81, then 3x rotate left.
  - Required: q_out=8'h03, 8'h06, 8'h0C in turn. Then 1x rotate right gives 8'h06; word_done_out stays 0 throughout.
- Deserialize:
  - After a clear, 8x shift left with ser_lsb_in = 1,0,1,1,0,0,1,0.
  - Required: q_out=8'hB2 and word_done_out=1 for exactly one cycle.
  - Continuing 8 more shifts gives a second pulse 8 cycles later.
- Enable gating:
  - During the deserialize above, drop en_in for 3 cycles after the 4th shift.
  - Required: q_out and the count freeze; the pulse arrives after the 8th enabled shift.
  - With en_in dropped in the pulse cycle, word_done_out stays high until the next enabled edge.
- Mid-word interrupt:
  - Do 5 shifts right, then load 8'h3C, then 8 shifts right with ser_msb_in=0.
  - Required: no pulse after the load; a pulse after the 8th post-load shift, with q_out=8'h00.
  - ser_lsb_out sequence during those 8 shifts: 0,0,1,1,1,1,0,0.
- Invert and clear:
  - Load 8'h5A, then invert.
  - Required: q_out=8'hA5. Then clear gives 8'h00.
  - Reset asserted on the 8th shift edge gives RESET_VAL with no pulse.
